// File: rtl/instr_queue_mw.sv
// Multi-wide instruction queue between fetch and decode.
// Up to FETCH_W entries enter per cycle as one all-or-nothing group, compacted
// in lane order. Up to DECODE_W entries leave per cycle from the head.
// Optional macro IQ_POP_FREES_PUSH_EN: when defined, slots released by the
// same-cycle pop count as free space for the incoming fetch group.
module instr_queue_mw #(
  parameter int DEPTH    = 8,
  parameter int FETCH_W  = 2,
  parameter int DECODE_W = 2
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          flush,
  input  logic [FETCH_W-1:0]            push_valid,
  input  logic [FETCH_W*32-1:0]         push_pc,
  input  logic [FETCH_W*32-1:0]         push_pc_next,
  input  logic [FETCH_W*32-1:0]         push_instr,
  output logic                          push_ready,
  input  logic [$clog2(DECODE_W+1)-1:0] pop_cnt,
  output logic [DECODE_W-1:0]           out_valid,
  output logic [DECODE_W*32-1:0]        out_pc,
  output logic [DECODE_W*32-1:0]        out_pc_next,
  output logic [DECODE_W*32-1:0]        out_instr,
  output logic [$clog2(DEPTH+1)-1:0]    count,
  output logic                          full,
  output logic                          empty
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);

  if (((DEPTH & (DEPTH - 1)) != 0) || (DEPTH < 2) || (DEPTH < FETCH_W) || (DEPTH < DECODE_W))
  begin : g_param_check
    $error("instr_queue_mw: DEPTH must be a power of two and >= FETCH_W and DECODE_W");
  end

  logic [31:0]   mem_pc      [DEPTH];
  logic [31:0]   mem_pc_next [DEPTH];
  logic [31:0]   mem_instr   [DEPTH];

  logic [PW-1:0] head_q, tail_q;
  logic [CW-1:0] count_q;
  logic [CW-1:0] n_push, n_pop;
  logic [CW:0]   free_slots;
  logic          ready_raw, accept;
  logic [PW-1:0] wr_idx [FETCH_W];
  logic [PW-1:0] rd_idx [DECODE_W];

  // Count valid push lanes and give each one its compacted slot past the tail.
  always_comb begin
    n_push = '0;
    for (int i = 0; i < FETCH_W; i++) begin
      wr_idx[i] = tail_q + PW'(n_push);
      n_push    = n_push + CW'(push_valid[i]);
    end
  end

  // Pop request is clamped to occupancy; decide whether the whole group fits.
  always_comb begin
    n_pop = (CW'(pop_cnt) > count_q) ? count_q : CW'(pop_cnt);
`ifdef IQ_POP_FREES_PUSH_EN
    free_slots = (CW+1)'(DEPTH) - {1'b0, count_q} + {1'b0, n_pop};
`else
    free_slots = (CW+1)'(DEPTH) - {1'b0, count_q};
`endif
    ready_raw = (free_slots >= (CW+1)'(FETCH_W));
    accept    = ready_raw && (|push_valid) && !flush && !rst;
  end

  // Pointer and occupancy update; reset and flush both empty the queue.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_q + PW'(n_pop);
      if (accept) tail_q <= tail_q + PW'(n_push);
      count_q <= count_q + (accept ? n_push : '0) - n_pop;
    end
  end

  // Storage write for accepted lanes; contents are not cleared by reset.
  always_ff @(posedge clk) begin
    for (int i = 0; i < FETCH_W; i++) begin
      if (accept && push_valid[i]) begin
        mem_pc[wr_idx[i]]      <= push_pc[32*i +: 32];
        mem_pc_next[wr_idx[i]] <= push_pc_next[32*i +: 32];
        mem_instr[wr_idx[i]]   <= push_instr[32*i +: 32];
      end
    end
  end

  // Output lanes read head+j; lanes beyond occupancy are forced to zero.
  always_comb begin
    out_valid   = '0;
    out_pc      = '0;
    out_pc_next = '0;
    out_instr   = '0;
    for (int j = 0; j < DECODE_W; j++) begin
      rd_idx[j] = head_q + PW'(j);
      if (!rst && (CW'(j) < count_q)) begin
        out_valid[j]           = 1'b1;
        out_pc[32*j +: 32]      = mem_pc[rd_idx[j]];
        out_pc_next[32*j +: 32] = mem_pc_next[rd_idx[j]];
        out_instr[32*j +: 32]   = mem_instr[rd_idx[j]];
      end
    end
  end

  // Status outputs show the empty state while reset is held.
  always_comb begin
    push_ready = rst ? 1'b1 : ready_raw;
    count      = rst ? '0 : count_q;
    empty      = rst || (count_q == '0);
    full       = !rst && (count_q == CW'(DEPTH));
  end

endmodule

// File: tb/tb_instr_queue_mw.sv
// Scoreboard bench for instr_queue_mw (DEPTH=8, FETCH_W=2, DECODE_W=2).
module tb_instr_queue_mw;

  logic        clk = 1'b0;
  logic        rst, flush;
  logic [1:0]  push_valid;
  logic [63:0] push_pc, push_pc_next, push_instr;
  logic        push_ready;
  logic [1:0]  pop_cnt;
  logic [1:0]  out_valid;
  logic [63:0] out_pc, out_pc_next, out_instr;
  logic [3:0]  count;
  logic        full, empty;

  int          vectors = 0;
  int          errors  = 0;
  int          ecnt;
  logic [31:0] exp_q[$];

  instr_queue_mw #(.DEPTH(8), .FETCH_W(2), .DECODE_W(2)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .push_valid(push_valid), .push_pc(push_pc), .push_pc_next(push_pc_next),
    .push_instr(push_instr), .push_ready(push_ready), .pop_cnt(pop_cnt),
    .out_valid(out_valid), .out_pc(out_pc), .out_pc_next(out_pc_next),
    .out_instr(out_instr), .count(count), .full(full), .empty(empty)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic [1:0] pv, input logic [31:0] i0, input logic [31:0] i1,
                       input logic [1:0] pc, input logic fl);
    push_valid   = pv;
    push_instr   = {i1, i0};
    push_pc      = {i1 << 2, i0 << 2};
    push_pc_next = {(i1 << 2) + 32'd4, (i0 << 2) + 32'd4};
    pop_cnt      = pc;
    flush        = fl;
  endtask

  task automatic idle();
    drive(2'b00, 32'h0, 32'h0, 2'd0, 1'b0);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Monitor: entries leaving at the next edge must match the scoreboard in order.
  always @(negedge clk) begin
    if (!rst && !flush) begin
      for (int j = 0; j < 2; j++) begin
        if (j < int'(pop_cnt) && out_valid[j]) begin
          logic [31:0] e;
          vectors++;
          if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL pop_unexpected lane%0d: got instr %0h, expected none", j, out_instr[32*j +: 32]);
          end else begin
            e = exp_q.pop_front();
            if (out_instr[32*j +: 32] !== e || out_pc[32*j +: 32] !== (e << 2) ||
                out_pc_next[32*j +: 32] !== ((e << 2) + 32'd4)) begin
              errors++;
              $display("FAIL pop_data lane%0d: got instr %0h pc %0h pcn %0h, expected instr %0h pc %0h pcn %0h",
                       j, out_instr[32*j +: 32], out_pc[32*j +: 32], out_pc_next[32*j +: 32],
                       e, e << 2, (e << 2) + 32'd4);
            end
          end
        end
      end
    end
  end

  initial begin
    // Reset held with busy inputs
    rst = 1'b1;
    drive(2'b11, 32'h11, 32'h22, 2'd2, 1'b0);
    tick(); tick();
    chk("rst_count", 64'(count), 64'd0);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_empty", 64'(empty), 64'd1);
    chk("rst_full", 64'(full), 64'd0);
    chk("rst_push_ready", 64'(push_ready), 64'd1);

    // Basic push of A, B
    rst = 1'b0;
    drive(2'b11, 32'hA, 32'hB, 2'd0, 1'b0);
    exp_q.push_back(32'hA); exp_q.push_back(32'hB);
    #1 chk("no_bypass", 64'(out_valid), 64'd0);
    tick(); idle();
    chk("ab_count", 64'(count), 64'd2);
    chk("ab_out_valid", 64'(out_valid), 64'd3);
    chk("ab_lane0", 64'(out_instr[31:0]), 64'hA);
    chk("ab_lane1", 64'(out_instr[63:32]), 64'hB);

    // Fill to 7, then rejected groups
    drive(2'b11, 32'h10, 32'h11, 2'd0, 1'b0);
    exp_q.push_back(32'h10); exp_q.push_back(32'h11); tick();
    drive(2'b11, 32'h12, 32'h13, 2'd0, 1'b0);
    exp_q.push_back(32'h12); exp_q.push_back(32'h13); tick();
    drive(2'b01, 32'h14, 32'hBAD, 2'd0, 1'b0);
    exp_q.push_back(32'h14); tick(); idle();
    chk("fill7_count", 64'(count), 64'd7);
    drive(2'b11, 32'hE0, 32'hE1, 2'd0, 1'b0);
    #1 chk("fill7_ready", 64'(push_ready), 64'd0);
    tick();
    chk("rej2_count", 64'(count), 64'd7);
    drive(2'b01, 32'hE2, 32'h0, 2'd0, 1'b0);
    tick(); idle();
    chk("rej1_count", 64'(count), 64'd7);

    // Reach full
    drive(2'b00, 32'h0, 32'h0, 2'd1, 1'b0); tick();
    drive(2'b11, 32'h20, 32'h21, 2'd0, 1'b0);
    exp_q.push_back(32'h20); exp_q.push_back(32'h21); tick(); idle();
    chk("full_count", 64'(count), 64'd8);
    chk("full_flag", 64'(full), 64'd1);
    chk("full_ready", 64'(push_ready), 64'd0);

    // Pop 2 + push 2 while full
    drive(2'b11, 32'h30, 32'h31, 2'd2, 1'b0);
`ifdef IQ_POP_FREES_PUSH_EN
    exp_q.push_back(32'h30); exp_q.push_back(32'h31);
    #1 chk("pp_ready", 64'(push_ready), 64'd1);
    tick(); idle();
    chk("pp_count", 64'(count), 64'd8);
    ecnt = 8;
`else
    #1 chk("pp_ready", 64'(push_ready), 64'd0);
    tick(); idle();
    chk("pp_count", 64'(count), 64'd6);
    ecnt = 6;
`endif

    // Drain to 1, then over-pop
    while (ecnt > 2) begin
      drive(2'b00, 32'h0, 32'h0, 2'd2, 1'b0); tick(); ecnt -= 2;
    end
    drive(2'b00, 32'h0, 32'h0, 2'd1, 1'b0); tick(); idle();
    chk("one_count", 64'(count), 64'd1);
    chk("one_out_valid", 64'(out_valid), 64'd1);
    drive(2'b00, 32'h0, 32'h0, 2'd2, 1'b0); tick(); idle();
    chk("clamp_count", 64'(count), 64'd0);
    chk("clamp_empty", 64'(empty), 64'd1);
    chk("clamp_out_valid", 64'(out_valid), 64'd0);
    chk("clamp_instr_zero", out_instr, 64'd0);
    chk("clamp_pc_zero", out_pc, 64'd0);
    chk("clamp_pcn_zero", out_pc_next, 64'd0);

    // Streaming push 2 / pop 2 across several wraps
    for (int k = 0; k < 20; k++) begin
      drive(2'b11, 32'h1000 + 32'(2*k), 32'h1001 + 32'(2*k), 2'd2, 1'b0);
      exp_q.push_back(32'h1000 + 32'(2*k)); exp_q.push_back(32'h1001 + 32'(2*k));
      tick();
    end
    idle();
    chk("stream_count", 64'(count), 64'd2);
    chk("stream_last_lane1", 64'(out_instr[63:32]), 64'h1027);
    drive(2'b00, 32'h0, 32'h0, 2'd2, 1'b0); tick(); idle();
    chk("stream_drained", 64'(count), 64'd0);

    // Flush with simultaneous push and pop
    drive(2'b11, 32'h40, 32'h41, 2'd0, 1'b0);
    exp_q.push_back(32'h40); exp_q.push_back(32'h41); tick();
    drive(2'b11, 32'h42, 32'h43, 2'd0, 1'b0);
    exp_q.push_back(32'h42); exp_q.push_back(32'h43); tick();
    drive(2'b10, 32'hBAD0, 32'h44, 2'd0, 1'b0);
    exp_q.push_back(32'h44); tick(); idle();
    chk("pre_flush_count", 64'(count), 64'd5);
    chk("pre_flush_head", 64'(out_instr[31:0]), 64'h40);
    drive(2'b11, 32'h50, 32'h51, 2'd2, 1'b1);
    exp_q.delete();
    tick(); idle();
    chk("flush_count", 64'(count), 64'd0);
    chk("flush_empty", 64'(empty), 64'd1);
    chk("flush_out_valid", 64'(out_valid), 64'd0);
    tick();
    chk("flush_no_late_push", 64'(count), 64'd0);
    drive(2'b11, 32'h60, 32'h61, 2'd0, 1'b0);
    exp_q.push_back(32'h60); exp_q.push_back(32'h61); tick(); idle();
    chk("post_flush_count", 64'(count), 64'd2);
    chk("post_flush_lane0", 64'(out_instr[31:0]), 64'h60);

    // Reset mid-operation
    rst = 1'b1; exp_q.delete(); tick();
    rst = 1'b0; #1;
    chk("midrst_count", 64'(count), 64'd0);
    chk("midrst_out_valid", 64'(out_valid), 64'd0);

    // Final push/pop, then scoreboard must be empty
    drive(2'b11, 32'h70, 32'h71, 2'd0, 1'b0);
    exp_q.push_back(32'h70); exp_q.push_back(32'h71); tick();
    drive(2'b00, 32'h0, 32'h0, 2'd2, 1'b0); tick(); idle(); tick();
    chk("final_count", 64'(count), 64'd0);
    chk("scoreboard_drained", 64'(exp_q.size()), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
